// File: rtl/output_requant_packer_if.sv
// Handshake bundle for output_requant_packer: accumulator stream in, packed words out.
// The master modport belongs to the producer/consumer side and the slave modport to the packer.
interface output_requant_packer_if #(
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int IO_DATA_WIDTH      = 8,
    parameter int MEM_BW             = 128,
    parameter int SHIFT_WIDTH        = 5
) ();
    localparam int LANES = MEM_BW / IO_DATA_WIDTH;

    logic [ACCUMULATION_WIDTH-1:0] acc_in;
    logic                          acc_valid;
    logic                          acc_last;
    logic                          acc_ready;
    logic [SHIFT_WIDTH-1:0]        shift_amount;
    logic                          relu_en;
    logic [MEM_BW-1:0]             packed_out;
    logic [LANES-1:0]              packed_byte_en;
    logic                          packed_valid;
    logic                          packed_ready;

    modport master (
        output acc_in, acc_valid, acc_last, shift_amount, relu_en, packed_ready,
        input  acc_ready, packed_out, packed_byte_en, packed_valid
    );

    modport slave (
        input  acc_in, acc_valid, acc_last, shift_amount, relu_en, packed_ready,
        output acc_ready, packed_out, packed_byte_en, packed_valid
    );
endinterface

// File: rtl/output_requant_packer.sv
// Requantizes signed accumulators (round-half-up shift, optional ReLU, saturate) and packs lanes into MEM_BW words; define OUTPUT_REQUANT_STATS_EN for sat_count.
// Latency: packed_valid rises one cycle after the accept that completes a word (FIFO empty); 1 element/cycle sustained.
// Backpressure: 2-entry FWFT output FIFO; acc_ready is registered and low while the FIFO holds 2 words.

// Generic first-word-fall-through FIFO; pop_dat shows the head entry.
// Latency: an entry pushed on an edge is visible at the head after that edge when the FIFO was empty.
// Backpressure: caller must not push when full nor pop when empty; count is exported for that.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign pop_dat = mem[rd_ptr];
endmodule

module output_requant_packer #(
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int IO_DATA_WIDTH      = 8,
    parameter int MEM_BW             = 128,
    parameter int SHIFT_WIDTH        = 5
) (
    input  logic                   clk,
    input  logic                   arst_n_in,
    output_requant_packer_if.slave bus
`ifdef OUTPUT_REQUANT_STATS_EN
    ,
    output logic [15:0]            sat_count
`endif
);
    localparam int LANES = MEM_BW / IO_DATA_WIDTH;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int RW    = ACCUMULATION_WIDTH + 1;
    localparam int FW    = LANES + MEM_BW;

    // One extra bit keeps the rounding add from overflowing at the accumulator extremes.
    localparam logic signed [RW-1:0] Q_MAX = RW'((64'sd1 <<< (IO_DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [RW-1:0] Q_MIN = ~Q_MAX;

    logic signed [RW-1:0]     rnd;
    logic signed [RW-1:0]     r_sum;
    logic signed [RW-1:0]     r_shift;
    logic signed [RW-1:0]     r_relu;
    logic [IO_DATA_WIDTH-1:0] q_dat;

    logic                     acc_ready_q;
    logic                     accept;
    logic                     word_done;
    logic [LW-1:0]            lane_idx;
    logic [MEM_BW-1:0]        word_q;
    logic [MEM_BW-1:0]        word_nxt;
    logic [LANES-1:0]         mask_q;
    logic [LANES-1:0]         mask_nxt;

    logic                     pop;
    logic [1:0]               fifo_count;
    logic [1:0]               cnt_nxt;
    logic [FW-1:0]            head_dat;

    assign accept = bus.acc_valid && acc_ready_q;

    always_comb begin
        rnd = '0;
        if (bus.shift_amount != '0) begin
            rnd = RW'(1) << (bus.shift_amount - SHIFT_WIDTH'(1));
        end
        r_sum   = $signed({bus.acc_in[ACCUMULATION_WIDTH-1], bus.acc_in}) + rnd;
        r_shift = r_sum >>> bus.shift_amount;
        r_relu  = (bus.relu_en && r_shift[RW-1]) ? '0 : r_shift;
        q_dat   = r_relu[IO_DATA_WIDTH-1:0];
        if (r_relu > Q_MAX) begin
            q_dat = Q_MAX[IO_DATA_WIDTH-1:0];
        end else if (r_relu < Q_MIN) begin
            q_dat = Q_MIN[IO_DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        word_nxt = word_q;
        word_nxt[lane_idx*IO_DATA_WIDTH +: IO_DATA_WIDTH] = q_dat;
        mask_nxt  = mask_q | (LANES'(1) << lane_idx);
        word_done = accept && (bus.acc_last || (lane_idx == LW'(LANES - 1)));
    end

    // The partial word lives outside the FIFO and is cleared once it is handed over.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            lane_idx <= '0;
            word_q   <= '0;
            mask_q   <= '0;
        end else if (word_done) begin
            lane_idx <= '0;
            word_q   <= '0;
            mask_q   <= '0;
        end else if (accept) begin
            lane_idx <= lane_idx + LW'(1);
            word_q   <= word_nxt;
            mask_q   <= mask_nxt;
        end
    end

    assign pop = (fifo_count != 2'd0) && bus.packed_ready;

    always_comb begin
        cnt_nxt = fifo_count;
        if (word_done && !pop) begin
            cnt_nxt = fifo_count + 2'd1;
        end else if (!word_done && pop) begin
            cnt_nxt = fifo_count - 2'd1;
        end
    end

    // Registered from the next occupancy so packed_ready never reaches acc_ready combinationally.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            acc_ready_q <= 1'b0;
        end else begin
            acc_ready_q <= (cnt_nxt < 2'd2);
        end
    end

    fifo #(
        .WIDTH (FW),
        .DEPTH (2)
    ) u_out_fifo (
        .clk      (clk),
        .arst_n   (arst_n_in),
        .push     (word_done),
        .push_dat ({mask_nxt, word_nxt}),
        .pop      (pop),
        .pop_dat  (head_dat),
        .count    (fifo_count)
    );

    assign bus.acc_ready      = acc_ready_q;
    assign bus.packed_valid   = (fifo_count != 2'd0);
    assign bus.packed_out     = bus.packed_valid ? head_dat[MEM_BW-1:0] : '0;
    assign bus.packed_byte_en = bus.packed_valid ? head_dat[FW-1:MEM_BW] : '0;

`ifdef OUTPUT_REQUANT_STATS_EN
    logic sat_evt;

    assign sat_evt = (r_relu > Q_MAX) || (r_relu < Q_MIN);

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            sat_count <= '0;
        end else if (accept && sat_evt && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_output_requant_packer.sv
// Bench for output_requant_packer: table vectors, directed multi-cycle sequences and a randomized run
// checked against a lane-list reference model.
module tb_output_requant_packer;
    localparam int LANES = 16;

    typedef struct packed {
        logic [15:0]  m;
        logic [127:0] w;
    } word_t;

    typedef struct {
        int         acc;
        int         sh;
        bit         relu;
        bit         last;
        logic [7:0] q;
        bit         sat;
    } vec_t;

    logic clk = 1'b0;
    logic arst_n_in;
    always #5 clk = ~clk;

    output_requant_packer_if bus ();

`ifdef OUTPUT_REQUANT_STATS_EN
    logic [15:0] sat_count;
`endif

    output_requant_packer dut (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .bus       (bus)
`ifdef OUTPUT_REQUANT_STATS_EN
        ,
        .sat_count (sat_count)
`endif
    );

    word_t        exp_q[$];
    logic [7:0]   lanes[$];
    int           m_sat = 0;
    int           checks = 0;
    int           errors = 0;
    bit           ready_mode = 1'b0;
    bit           ready_fixed = 1'b1;
    bit           hold_vld = 1'b0;
    logic [143:0] hold_dat;
    word_t        mon_w;
    vec_t         tbl [16];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, act, exp);
        end
    endtask

    // Spec arithmetic on wide integers: round-half-up, floor shift, ReLU, then clip.
    function automatic logic [7:0] ref_q(input int acc, input int sh, input bit relu, output bit sat);
        longint r;
        r = longint'(acc);
        if (sh > 0) r = r + (longint'(1) << (sh - 1));
        r = r >>> sh;
        if (relu && r < 0) r = 0;
        sat = 1'b0;
        if (r > 127) begin
            r = 127;
            sat = 1'b1;
        end else if (r < -128) begin
            r = -128;
            sat = 1'b1;
        end
        return r[7:0];
    endfunction

    task automatic model_accept(input logic [7:0] q, input bit last, input bit sat);
        word_t w;
        lanes.push_back(q);
        if (sat && m_sat < 65535) m_sat++;
        if (last || lanes.size() == LANES) begin
            w = '0;
            foreach (lanes[i]) begin
                w.w[i*8 +: 8] = lanes[i];
                w.m[i]        = 1'b1;
            end
            exp_q.push_back(w);
            lanes.delete();
        end
    endtask

    task automatic send(input int acc, input int sh, input bit relu, input bit last,
                        input logic [7:0] q, input bit sat);
        int n;
        bus.acc_in       = acc;
        bus.shift_amount = sh[4:0];
        bus.relu_en      = relu;
        bus.acc_last     = last;
        bus.acc_valid    = 1'b1;
        n = 0;
        while (!bus.acc_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.acc_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout acc_ready=0 required=1");
            bus.acc_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.acc_valid = 1'b0;
        model_accept(q, last, sat);
    endtask

    task automatic send_rand(input bit last);
        int         acc;
        int         sh;
        bit         relu;
        bit         sat;
        logic [7:0] q;
        case ($urandom_range(0, 2))
            0:       acc = int'($urandom_range(0, 4000)) - 2000;
            1:       acc = int'($urandom_range(0, 400000)) - 200000;
            default: acc = int'($urandom);
        endcase
        sh   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 10));
        relu = ($urandom_range(0, 1) == 1);
        q    = ref_q(acc, sh, relu, sat);
        send(acc, sh, relu, last, q, sat);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_valid", bus.packed_valid, 1'b0);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        bus.packed_ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_fixed;
    end

    // Consumer-side monitor: word order/content on every pop, stability while stalled.
    always @(negedge clk) begin
        if (!arst_n_in) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                chk("hold_stable", {bus.packed_valid, bus.packed_byte_en, bus.packed_out}, {1'b1, hold_dat});
            end
            hold_vld = bus.packed_valid && !bus.packed_ready;
            hold_dat = {bus.packed_byte_en, bus.packed_out};
            if (bus.packed_valid && bus.packed_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word got=%0h required=none", bus.packed_out);
                end else begin
                    mon_w = exp_q.pop_front();
                    chk("word_dat", bus.packed_out, mon_w.w);
                    chk("word_mask", bus.packed_byte_en, mon_w.m);
                end
            end
        end
    end

    initial begin
        arst_n_in        = 1'b0;
        bus.acc_in       = '0;
        bus.acc_valid    = 1'b0;
        bus.acc_last     = 1'b0;
        bus.shift_amount = '0;
        bus.relu_en      = 1'b0;
        bus.packed_ready = 1'b0;

        tbl[0]  = '{1000,          4,  1'b0, 1'b0, 8'h3F, 1'b0};
        tbl[1]  = '{-1000,         4,  1'b0, 1'b0, 8'hC2, 1'b0};
        tbl[2]  = '{5000,          4,  1'b0, 1'b0, 8'h7F, 1'b1};
        tbl[3]  = '{-5000,         4,  1'b0, 1'b1, 8'h80, 1'b1};
        tbl[4]  = '{-1000,         4,  1'b1, 1'b0, 8'h00, 1'b0};
        tbl[5]  = '{1000,          4,  1'b1, 1'b1, 8'h3F, 1'b0};
        tbl[6]  = '{127,           0,  1'b0, 1'b0, 8'h7F, 1'b0};
        tbl[7]  = '{128,           0,  1'b0, 1'b1, 8'h7F, 1'b1};
        tbl[8]  = '{7,             1,  1'b0, 1'b1, 8'h04, 1'b0};
        tbl[9]  = '{-8,            4,  1'b0, 1'b0, 8'h00, 1'b0};
        tbl[10] = '{-9,            4,  1'b0, 1'b0, 8'hFF, 1'b0};
        tbl[11] = '{24,            4,  1'b0, 1'b0, 8'h02, 1'b0};
        tbl[12] = '{32'sh7FFFFFFF, 31, 1'b0, 1'b0, 8'h01, 1'b0};
        tbl[13] = '{32'sh80000000, 31, 1'b0, 1'b0, 8'hFF, 1'b0};
        tbl[14] = '{-5000,         0,  1'b1, 1'b0, 8'h00, 1'b0};
        tbl[15] = '{-200,          0,  1'b0, 1'b1, 8'h80, 1'b1};

        #3;
        chk("reset_valid", bus.packed_valid, 1'b0);
        chk("reset_out", bus.packed_out, 128'h0);
        chk("reset_mask", bus.packed_byte_en, 16'h0);
        chk("reset_acc_ready", bus.acc_ready, 1'b0);
`ifdef OUTPUT_REQUANT_STATS_EN
        chk("reset_sat_count", sat_count, 16'h0);
`endif
        @(posedge clk);
        #1;
        arst_n_in = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", bus.acc_ready, 1'b1);

        for (int i = 0; i < 16; i++) begin
            send(tbl[i].acc, tbl[i].sh, tbl[i].relu, tbl[i].last, tbl[i].q, tbl[i].sat);
`ifdef OUTPUT_REQUANT_STATS_EN
            if (i == 3) chk("sat_count_first_word", sat_count, 16'd2);
            if (i == 5) chk("sat_count_relu_word", sat_count, 16'd2);
`endif
        end
        wait_drain();

        for (int i = 0; i < 16; i++) begin
            send(i * 16, 4, 1'b0, 1'b0, i[7:0], 1'b0);
            if (i == 14) chk("no_early_valid", bus.packed_valid, 1'b0);
        end
        chk("ramp_valid_latency", bus.packed_valid, 1'b1);
        chk("ramp_word", bus.packed_out, 128'h0F0E0D0C0B0A09080706050403020100);
        chk("ramp_mask", bus.packed_byte_en, 16'hFFFF);
        wait_drain();

        ready_fixed = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) send_rand(1'b0);
        chk("full_acc_ready_low", bus.acc_ready, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("full_still_blocked", bus.acc_ready, 1'b0);
        chk("full_valid", bus.packed_valid, 1'b1);
        ready_fixed = 1'b1;
        for (int i = 0; i < 16; i++) send_rand(1'b0);
        wait_drain();

        ready_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_rand($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        send_rand(1'b1);
        ready_mode  = 1'b0;
        ready_fixed = 1'b1;
        wait_drain();
`ifdef OUTPUT_REQUANT_STATS_EN
        chk("sat_count_random", sat_count, m_sat);
`endif

        for (int i = 0; i < 7; i++) send_rand(1'b0);
        arst_n_in = 1'b0;
        #2;
        chk("midreset_valid", bus.packed_valid, 1'b0);
        chk("midreset_out", bus.packed_out, 128'h0);
        chk("midreset_mask", bus.packed_byte_en, 16'h0);
        chk("midreset_acc_ready", bus.acc_ready, 1'b0);
`ifdef OUTPUT_REQUANT_STATS_EN
        chk("midreset_sat_count", sat_count, 16'h0);
`endif
        lanes.delete();
        exp_q.delete();
        m_sat = 0;
        @(posedge clk);
        #1;
        arst_n_in = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) send_rand(1'b0);
        chk("post_reset_valid", bus.packed_valid, 1'b1);
        chk("post_reset_mask", bus.packed_byte_en, 16'hFFFF);
        wait_drain();
`ifdef OUTPUT_REQUANT_STATS_EN
        chk("sat_count_post_reset", sat_count, m_sat);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/output_requant_packer.md
Name: output_requant_packer

Overview:
Downstream stage of top_system. Consumes the signed ACCUMULATION_WIDTH partial-sum/accumulator stream the PE array produces. Requantizes each value to IO_DATA_WIDTH using round-half-up arithmetic right shift, optional ReLU and saturation. Packs LANES = MEM_BW/IO_DATA_WIDTH results into MEM_BW-wide words for the output activation memory or off-chip port, with a 2-entry output FIFO and valid/ready on both sides.

Parameters:
ACCUMULATION_WIDTH, 32, width of signed input accumulator
IO_DATA_WIDTH, 8, width of signed output activation
MEM_BW, 128, packed output word width; must be a multiple of IO_DATA_WIDTH (LANES = 16 at defaults)
SHIFT_WIDTH, 5, width of requantization shift amount

Ports:
clk  in  1  clock, all logic on rising edge
arst_n_in  in  1  asynchronous active-low reset
acc_in  in  ACCUMULATION_WIDTH  signed accumulator value
acc_valid  in  1  acc_in valid
acc_last  in  1  final element of an output group; flushes partial word
acc_ready  out  1  block accepts acc_in this cycle
shift_amount  in  SHIFT_WIDTH  right-shift amount, unsigned
relu_en  in  1  clamp negative results to 0
packed_out  out  MEM_BW  packed word; lane 0 in bits [IO_DATA_WIDTH-1:0]
packed_byte_en  out  LANES  per-lane valid mask for packed_out
packed_valid  out  1  packed_out valid
packed_ready  in  1  consumer accepts packed_out
sat_count  out  16  saturation event counter (present only with OUTPUT_REQUANT_STATS_EN)

Behaviour:
- Reset (async assert, sync-to-clk deassert not required inside block): packed_out=0, packed_byte_en=0, packed_valid=0, acc_ready=0 during reset then 1, lane index=0, FIFO empty, sat_count=0. Reset mid-operation discards any partial word and FIFO contents.
- Accept = acc_valid && acc_ready. acc_ready = (fifo_count < 2). Registered, no combinational path from packed_ready.
- Requant, combinational on accept, in ACCUMULATION_WIDTH+1 bits:
  - r = acc_in + (shift_amount>0 ? 1<<(shift_amount-1) : 0)
  - r = r >>> shift_amount (arithmetic)
  - if relu_en and r<0, then r=0
  - saturate to [-2^(IO_DATA_WIDTH-1), 2^(IO_DATA_WIDTH-1)-1]
  - saturation event = clipping by the saturate step only.
- Pack: result written to lane at lane index; lane bit set in mask; lane index increments.
- Word completes on accept when lane index==LANES-1 or acc_last=1. The completed word (unfilled lanes = 0, mask = filled lanes) is pushed to the FIFO on that same edge. Lane index and mask reset to 0.
- Latency: packed_valid rises the cycle after the completing accept (FIFO empty case).
- FIFO: 2 entries, FWFT; packed_out/packed_byte_en/packed_valid driven from the head entry.
  - Pop on packed_valid && packed_ready.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Push never occurs at count==2 (acc_ready low).
- packed_out is held stable while packed_valid && !packed_ready.
- shift_amount and relu_en are sampled per accept. Changing them mid-word is legal and applies per element.
- acc_last with lane index 0 and no prior lanes: emits a 1-lane word (mask=0x0001).
- Throughput: 1 element/cycle while packed_ready is held high.

Optional Feature:
OUTPUT_REQUANT_STATS_EN: when defined, sat_count port exists. It increments by 1 per accepted element whose value was clipped by saturation, holds at 0xFFFF (no wrap), and resets to 0. When undefined, the port and counter are absent and requant behaviour is identical.

Test Plan:
- shift=4, relu_en=0, inputs 1000, -1000, 5000, -5000 with acc_last on 4th -> lanes 0x3F, 0xC2, 0x7F, 0x80; mask=0x000F; sat_count=2 with STATS_EN.
- shift=4, relu_en=1, input -1000 then 1000 with acc_last -> lanes 0x00, 0x3F; mask=0x0003; sat_count unchanged.
- shift=4, 16 accepts acc_in=i*16 (i=0..15), packed_ready=1 -> one word 0x0F0E0D0C0B0A09080706050403020100, mask=0xFFFF, packed_valid one cycle after 16th accept.
- packed_ready=0, stream 48 values continuously -> acc_ready low after 32nd accept. Two words held stable. Raising packed_ready drains both in order and resumes acceptance; third word correct.
- shift=0, input 127 then 128 with acc_last -> 0x7F, 0x7F (second saturates).
- Assert arst_n_in after 7 accepts -> all outputs 0. Subsequent 16 accepts produce one clean full word with no residue.
